dram_amux_nbank: RTL



---
 rtl/dram_amux_pkg.sv | 11 +
 rtl/dram_amux_nbank_if.sv | 10 +
 rtl/dram_amux_refcnt.sv | 40 ++++
 rtl/dram_amux_nbank.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/dram_amux_pkg.sv
// Shared types and constants for the multi-bank DRAM address multiplexer.
package dram_amux_pkg;
    typedef enum logic [1:0] {IDLE, ROW, COL} amux_state_e;

    localparam int REF_UNIT = 64;

    // column width code 0..3 -> 8..11 address bits
    function automatic logic [3:0] colw_bits(input logic [1:0] code);
        return 4'd8 + {2'b00, code};
    endfunction
endpackage

// File: rtl/dram_amux_nbank_if.sv
// Request-side handshake between the address arbiter and the address mux.
interface dram_amux_nbank_if #(parameter int AW = 24);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_len;

    modport master (output req_valid, req_addr, req_len, input req_ready);
    modport slave  (input req_valid, req_addr, req_len, output req_ready);
endinterface

// File: rtl/dram_amux_refcnt.sv
// Refresh interval counter ((rate+1)*REF_UNIT clocks) feeding a pending count saturating at 3.
module dram_amux_refcnt
    import dram_amux_pkg::*;
#(
    parameter int REFW = 4
) (
    input  logic            clk,
    input  logic            resetl,
    input  logic [REFW-1:0] cfg_refrate,
    input  logic            ack,
    output logic            ref_req,
    output logic [1:0]      ref_pend
);
    localparam int CW = REFW + $clog2(REF_UNIT) + 1;

    logic [CW-1:0]   cnt, limit;
    logic [REFW-1:0] rate_q;
    logic            rate_chg, wrap;

    assign limit    = (CW'(cfg_refrate) + CW'(1)) * CW'(REF_UNIT);
    assign rate_chg = rate_q != cfg_refrate;
    assign wrap     = !rate_chg && (cnt == limit - CW'(1));
    assign ref_req  = ref_pend != 2'd0;

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            cnt      <= '0;
            rate_q   <= '0;
            ref_pend <= 2'd0;
        end else begin
            rate_q <= cfg_refrate;
            cnt    <= (rate_chg || wrap) ? '0 : cnt + CW'(1);
            // a wrap and an ack in the same cycle cancel out
            if (wrap && !ack && ref_pend != 2'd3)
                ref_pend <= ref_pend + 2'd1;
            else if (ack && !wrap && ref_pend != 2'd0)
                ref_pend <= ref_pend - 2'd1;
        end
    end
endmodule

// File: rtl/dram_amux_nbank.sv
// Multi-bank DRAM address mux: open-row tracking, row/column strobe sequencing, refresh requests.
// Optional burst columns via DRAM_AMUX_BURST_EN (req_len+1 beats); default is single beat.
module dram_amux_nbank
    import dram_amux_pkg::*;
#(
    parameter int AW    = 24,
    parameter int MAW   = 11,
    parameter int NBANK = 2,
    parameter int BKW   = $clog2(NBANK),
    parameter int REFW  = 4
) (
    input  logic               clk,
    input  logic               resetl,
    dram_amux_nbank_if.slave   req,
    input  logic [2*NBANK-1:0] cfg_colw,
    input  logic [REFW-1:0]    cfg_refrate,
    input  logic               ref_ack,
    output logic [MAW-1:0]     ma,
    output logic               row_stb,
    output logic               col_stb,
    output logic               page_hit,
    output logic [BKW-1:0]     bank_sel,
    output logic               done,
    output logic               ref_req,
    output logic [1:0]         ref_pend
);
    amux_state_e state, state_nxt;

    logic                      acc, ack_ok, hit;
    logic [BKW-1:0]            a_bank;
    logic [3:0]                a_cbits;
    logic [AW-BKW-1:0]         a_low, a_mask;
    logic [MAW-1:0]            a_row, a_col;
    logic [1:0]                a_len;
    logic [NBANK-1:0]          row_vld;
    logic [NBANK-1:0][MAW-1:0] row_tab;
    logic [MAW-1:0]            col_q, mask_q, col_inc;
    logic [1:0]                rem_q;
    logic [MAW-1:0]            ma_d;
    logic [BKW-1:0]            bank_d;
    logic                      row_d, col_d, hit_d, done_d;

    assign req.req_ready = (state == IDLE) && !ref_req;
    assign acc     = req.req_valid && req.req_ready;
    assign ack_ok  = ref_ack && (state == IDLE);

    // split is taken from the live config only at accept, then latched
    assign a_bank  = req.req_addr[AW-1 -: BKW];
    assign a_low   = req.req_addr[AW-BKW-1:0];
    assign a_cbits = colw_bits(cfg_colw[{a_bank, 1'b0} +: 2]);
    assign a_mask  = ~({(AW-BKW){1'b1}} << a_cbits);
    assign a_row   = MAW'(a_low >> a_cbits);
    assign a_col   = MAW'(a_low & a_mask);
    assign hit     = row_vld[a_bank] && !ack_ok && (row_tab[a_bank] == a_row);
    assign col_inc = (col_q + MAW'(1)) & mask_q;

`ifdef DRAM_AMUX_BURST_EN
    assign a_len = req.req_len;
`else
    logic unused_len;
    assign unused_len = ^req.req_len;
    assign a_len      = 2'd0;
`endif

    dram_amux_refcnt #(.REFW(REFW)) u_refcnt (
        .clk         (clk),
        .resetl      (resetl),
        .cfg_refrate (cfg_refrate),
        .ack         (ack_ok),
        .ref_req     (ref_req),
        .ref_pend    (ref_pend)
    );

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            state    <= IDLE;
            ma       <= '0;
            row_stb  <= 1'b0;
            col_stb  <= 1'b0;
            page_hit <= 1'b0;
            done     <= 1'b0;
            bank_sel <= '0;
        end else begin
            state    <= state_nxt;
            ma       <= ma_d;
            row_stb  <= row_d;
            col_stb  <= col_d;
            page_hit <= hit_d;
            done     <= done_d;
            bank_sel <= bank_d;
        end
    end

    // rem_q counts column beats still owed after the one currently being issued
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc) state_nxt = hit ? COL : ROW;
            ROW:     state_nxt = COL;
            COL:     if (rem_q == 2'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ma_d   = ma;
        bank_d = bank_sel;
        row_d  = 1'b0;
        col_d  = 1'b0;
        hit_d  = 1'b0;
        done_d = 1'b0;
        case (state)
            IDLE: if (acc) begin
                bank_d = a_bank;
                if (hit) begin
                    col_d  = 1'b1;
                    hit_d  = 1'b1;
                    ma_d   = a_col;
                    done_d = a_len == 2'd0;
                end else begin
                    row_d = 1'b1;
                    ma_d  = a_row;
                end
            end
            ROW: begin
                col_d  = 1'b1;
                ma_d   = col_q;
                done_d = rem_q == 2'd0;
            end
            COL: if (rem_q != 2'd0) begin
                col_d  = 1'b1;
                ma_d   = col_inc;
                done_d = rem_q == 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            row_vld <= '0;
            row_tab <= '0;
            col_q   <= '0;
            mask_q  <= '0;
            rem_q   <= 2'd0;
        end else begin
            if (ack_ok)
                row_vld <= '0;
            if (acc) begin
                col_q  <= a_col;
                mask_q <= MAW'(a_mask);
                rem_q  <= a_len;
                if (!hit) begin
                    row_vld[a_bank] <= 1'b1;
                    row_tab[a_bank] <= a_row;
                end
            end else if (state == COL && rem_q != 2'd0) begin
                col_q <= col_inc;
                rem_q <= rem_q - 2'd1;
            end
        end
    end
endmodule
